// File: rtl/bn_requant_pkg.sv
// Shared types and constants for the batch-norm / requantize stage.
package bn_requant_pkg;

  localparam int BN_N        = 16;
  localparam int BN_CHANNELS = 16;
  localparam int BN_Q        = 8;
  localparam int BN_CW       = $clog2(BN_CHANNELS);

  typedef logic [BN_CW-1:0] ch_idx_t;

  typedef struct packed {
    logic signed [BN_N-1:0] scale;
    logic signed [BN_N-1:0] bias;
  } coef_t;

  localparam logic signed [BN_N-1:0] SAT_MAX = {1'b0, {(BN_N-1){1'b1}}};
  localparam logic signed [BN_N-1:0] SAT_MIN = {1'b1, {(BN_N-1){1'b0}}};

  // 1.0 in a Q-fractional-bit fixed-point word
  function automatic logic signed [BN_N-1:0] q_one(input int q);
    return BN_N'(1 << q);
  endfunction

endpackage

// File: rtl/bn_coef_regfile.sv
// Per-channel {scale, bias} register file: one write port, registered read-before-write read port.
module bn_coef_regfile
  import bn_requant_pkg::*;
#(
  parameter int CHANNELS = BN_CHANNELS,
  parameter int Q        = BN_Q
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    wr_en,
  input  ch_idx_t wr_addr,
  input  coef_t   wr_coef,
  input  logic    rd_en,
  input  ch_idx_t rd_addr,
  output coef_t   rd_coef
);

  coef_t [CHANNELS-1:0] ents;

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ent
      coef_t ent;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ent.scale <= q_one(Q);
          ent.bias  <= '0;
        end else if (wr_en && (wr_addr == ch_idx_t'(c))) begin
          ent <= wr_coef;
        end
      end
      assign ents[c] = ent;
    end
  endgenerate

  // Same-edge write lands in the entry after this read samples it, so reads see the old value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_coef <= '0;
    end else if (rd_en && (32'(rd_addr) < CHANNELS)) begin
      rd_coef <= ents[rd_addr];
    end else begin
      rd_coef <= '0;
    end
  end

endmodule

// File: rtl/bn_requant.sv
// Per-channel y = sat((x*scale + bias) >> Q), 3-stage pipeline feeding the ReLU stage.
// Define BN_REQUANT_SAT_CNT_EN to add a saturating 32-bit sat_count output.
module bn_requant
  import bn_requant_pkg::*;
#(
  parameter int N        = BN_N,
  parameter int CHANNELS = BN_CHANNELS,
  parameter int Q        = BN_Q
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [N-1:0]         data_in,
  input  logic [$clog2(CHANNELS)-1:0] channel_in,
  input  logic                        valid_in,
  input  logic                        coef_wr_en,
  input  logic [$clog2(CHANNELS)-1:0] coef_wr_addr,
  input  logic signed [N-1:0]         coef_scale,
  input  logic signed [N-1:0]         coef_bias,
  output logic signed [N-1:0]         data_out,
  output logic [$clog2(CHANNELS)-1:0] channel_out,
  output logic                        valid_out,
  output logic                        sat_flag
`ifdef BN_REQUANT_SAT_CNT_EN
  ,
  output logic [31:0]                 sat_count
`endif
);

  localparam int CW     = $clog2(CHANNELS);
  localparam int SW     = 2*N + 1;
  localparam int STAGES = 2;  // vld_pipe[0]=S1 .. vld_pipe[STAGES]=S3
  localparam logic signed [SW-1:0] R_MAX = SW'(SAT_MAX);
  localparam logic signed [SW-1:0] R_MIN = SW'(SAT_MIN);

  logic [STAGES:0]       vld_pipe;
  logic signed [N-1:0]   x1;
  logic [CW-1:0]         ch1, ch2;
  coef_t                 c1;
  logic signed [2*N-1:0] prod;
  logic signed [SW-1:0]  bias_sh, sum, s2, r;
  logic                  sat_hi, sat_lo;

  bn_coef_regfile #(
    .CHANNELS (CHANNELS),
    .Q        (Q)
  ) u_coef (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (coef_wr_en),
    .wr_addr (coef_wr_addr),
    .wr_coef ({coef_scale, coef_bias}),
    .rd_en   (valid_in),
    .rd_addr (channel_in),
    .rd_coef (c1)
  );

  // S1: sample capture; coefficients arrive from the regfile's registered read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      x1       <= '0;
      ch1      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      if (valid_in) begin
        vld_pipe[0] <= 1'b1;
        x1          <= data_in;
        ch1         <= channel_in;
      end else begin
        x1  <= '0;
        ch1 <= '0;
      end
    end
  end

  // S2: product plus Q-aligned bias plus half-LSB for round-half-up
  always_comb begin
    prod    = (2*N)'(x1) * (2*N)'(c1.scale);
    bias_sh = SW'(c1.bias) <<< Q;
    sum     = SW'(prod) + bias_sh + (SW'(1) <<< (Q-1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2  <= '0;
      ch2 <= '0;
    end else if (vld_pipe[0]) begin
      s2  <= sum;
      ch2 <= ch1;
    end else begin
      s2  <= '0;
      ch2 <= '0;
    end
  end

  // S3: arithmetic shift and clamp to the N-bit signed range
  always_comb begin
    r      = s2 >>> Q;
    sat_hi = (r > R_MAX);
    sat_lo = (r < R_MIN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out    <= '0;
      channel_out <= '0;
      sat_flag    <= 1'b0;
    end else if (vld_pipe[1]) begin
      channel_out <= ch2;
      sat_flag    <= sat_hi | sat_lo;
      if (sat_hi)      data_out <= SAT_MAX;
      else if (sat_lo) data_out <= SAT_MIN;
      else             data_out <= r[N-1:0];
    end else begin
      data_out    <= '0;
      channel_out <= '0;
      sat_flag    <= 1'b0;
    end
  end

  assign valid_out = vld_pipe[STAGES];

`ifdef BN_REQUANT_SAT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (valid_out && sat_flag && (sat_count != '1)) begin
      sat_count <= sat_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bn_requant.sv
// Directed bench for bn_requant: arithmetic reference model plus hand-computed spot checks.
module tb_bn_requant;

  localparam int N  = 16;
  localparam int CH = 16;
  localparam int Q  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic signed [N-1:0] data_in = '0;
  logic [3:0]        channel_in = '0;
  logic              valid_in = 1'b0;
  logic              coef_wr_en = 1'b0;
  logic [3:0]        coef_wr_addr = '0;
  logic signed [N-1:0] coef_scale = '0;
  logic signed [N-1:0] coef_bias = '0;
  logic signed [N-1:0] data_out;
  logic [3:0]        channel_out;
  logic              valid_out;
  logic              sat_flag;
`ifdef BN_REQUANT_SAT_CNT_EN
  logic [31:0]       sat_count;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bn_requant #(.N(N), .CHANNELS(CH), .Q(Q)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .channel_in   (channel_in),
    .valid_in     (valid_in),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_scale   (coef_scale),
    .coef_bias    (coef_bias),
    .data_out     (data_out),
    .channel_out  (channel_out),
    .valid_out    (valid_out),
    .sat_flag     (sat_flag)
`ifdef BN_REQUANT_SAT_CNT_EN
    ,
    .sat_count    (sat_count)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct { bit v; int d; int ch; bit sat; } exp_t;
  localparam exp_t ZERO = '{v: 1'b0, d: 0, ch: 0, sat: 1'b0};

  int      m_scale [CH];
  int      m_bias  [CH];
  exp_t    pipe0, pipe1, exp_now;
  longint  m_satcnt;

  function automatic void calc(input int x, input int sc, input int bi,
                               output int d, output bit sat);
    longint s, r;
    s = longint'(x) * longint'(sc) + longint'(bi) * (64'sd1 << Q) + (64'sd1 << (Q-1));
    r = s >>> Q;
    if (r > 32767)       begin d = 32767;  sat = 1'b1; end
    else if (r < -32768) begin d = -32768; sat = 1'b1; end
    else                 begin d = int'(r); sat = 1'b0; end
  endfunction

  initial begin
    for (int c = 0; c < CH; c++) begin m_scale[c] = 256; m_bias[c] = 0; end
    pipe0 = ZERO; pipe1 = ZERO; exp_now = ZERO; m_satcnt = 0;
  end

  always @(posedge clk) begin
    exp_t n;
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin m_scale[c] = 256; m_bias[c] = 0; end
      pipe0 = ZERO; pipe1 = ZERO; exp_now = ZERO; m_satcnt = 0;
    end else begin
      n = ZERO;
      if (valid_in) begin
        n.v  = 1'b1;
        n.ch = int'(channel_in);
        if (n.ch < CH) calc(int'(data_in), m_scale[n.ch], m_bias[n.ch], n.d, n.sat);
        else           calc(int'(data_in), 0, 0, n.d, n.sat);
      end
      if (coef_wr_en && int'(coef_wr_addr) < CH) begin
        m_scale[coef_wr_addr] = int'(coef_scale);
        m_bias[coef_wr_addr]  = int'(coef_bias);
      end
      if (exp_now.v && exp_now.sat && m_satcnt != 64'hFFFF_FFFF) m_satcnt++;
      exp_now = pipe1;
      pipe1   = pipe0;
      pipe0   = n;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (valid_out != exp_now.v || int'(data_out) != exp_now.d ||
          int'(channel_out) != exp_now.ch || sat_flag != exp_now.sat) begin
        errors++;
        $display("FAIL stream @%0t: got v=%0b d=%0d ch=%0d sat=%0b, expected v=%0b d=%0d ch=%0d sat=%0b",
                 $time, valid_out, data_out, channel_out, sat_flag,
                 exp_now.v, exp_now.d, exp_now.ch, exp_now.sat);
      end
`ifdef BN_REQUANT_SAT_CNT_EN
      checks++;
      if (longint'(sat_count) != m_satcnt) begin
        errors++;
        $display("FAIL sat_count @%0t: got %0d, expected %0d", $time, sat_count, m_satcnt);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit v, input logic [3:0] ch, input logic [15:0] d,
                     input bit we, input logic [3:0] wa,
                     input logic [15:0] sc, input logic [15:0] bi);
    valid_in = v; channel_in = ch; data_in = d;
    coef_wr_en = we; coef_wr_addr = wa; coef_scale = sc; coef_bias = bi;
    @(posedge clk); #1;
    valid_in = 1'b0; coef_wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic lit(input string nm, input bit v, input int d, input int ch, input bit sat);
    checks++;
    if (valid_out != v || int'(data_out) != d || int'(channel_out) != ch || sat_flag != sat) begin
      errors++;
      $display("FAIL %s: got v=%0b d=%0d ch=%0d sat=%0b, expected v=%0b d=%0d ch=%0d sat=%0b",
               nm, valid_out, data_out, channel_out, sat_flag, v, d, ch, sat);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);
    lit("reset", 1'b0, 0, 0, 1'b0);
    rst_n = 1'b1;

    // default coefficients pass data through unchanged, 3-cycle latency
    cyc(1, 4'd0, 16'h0100, 0, 4'd0, 16'h0, 16'h0);
    cyc(1, 4'd0, 16'hFF00, 0, 4'd0, 16'h0, 16'h0);
    lit("dflt_latency", 1'b0, 0, 0, 1'b0);
    idle(1); lit("dflt_pos", 1'b1, 256, 0, 1'b0);
    idle(1); lit("dflt_neg", 1'b1, -256, 0, 1'b0);

    // 1.0 * 2.0 + 0.5 = 2.5
    cyc(0, 4'd0, 16'h0, 1, 4'd3, 16'h0200, 16'h0080);
    cyc(1, 4'd3, 16'h0100, 0, 4'd0, 16'h0, 16'h0);
    idle(2); lit("ch3_scaled", 1'b1, 640, 3, 1'b0);

    // half-LSB results round up
    cyc(0, 4'd0, 16'h0, 1, 4'd1, 16'h0080, 16'h0000);
    cyc(1, 4'd1, 16'h0001, 0, 4'd0, 16'h0, 16'h0);
    cyc(1, 4'd1, 16'hFFFF, 0, 4'd0, 16'h0, 16'h0);
    idle(1); lit("rnd_pos_half", 1'b1, 1, 1, 1'b0);
    idle(1); lit("rnd_neg_half", 1'b1, 0, 1, 1'b0);

    // saturation both ways
    cyc(0, 4'd0, 16'h0, 1, 4'd2, 16'h0400, 16'h0000);
    cyc(1, 4'd2, 16'h7000, 0, 4'd0, 16'h0, 16'h0);
    cyc(1, 4'd2, 16'h9000, 0, 4'd0, 16'h0, 16'h0);
    idle(1); lit("sat_hi", 1'b1, 32767, 2, 1'b1);
    idle(1); lit("sat_lo", 1'b1, -32768, 2, 1'b1);
`ifdef BN_REQUANT_SAT_CNT_EN
    idle(1);
    checks++;
    if (sat_count != 32'd2) begin
      errors++;
      $display("FAIL sat_count_lit: got %0d, expected 2", sat_count);
    end
`endif

    // same-cycle write/read: old value first, new value next
    cyc(1, 4'd5, 16'h0100, 1, 4'd5, 16'h0200, 16'h0000);
    cyc(1, 4'd5, 16'h0100, 0, 4'd0, 16'h0, 16'h0);
    idle(1); lit("coll_old", 1'b1, 256, 5, 1'b0);
    idle(1); lit("coll_new", 1'b1, 512, 5, 1'b0);

    // back-to-back stream with a one-cycle reset in the middle
    for (int i = 0; i < 20; i++) begin
      if (i == 10) rst_n = 1'b0;
      cyc(1, 4'(i % 6), 16'(i * 1237 - 9000), 0, 4'd0, 16'h0, 16'h0);
      if (i == 10) begin
        rst_n = 1'b1;
        lit("rst_flush", 1'b0, 0, 0, 1'b0);
      end
    end
    idle(3);

    // coefficients are back to 1.0 / 0 after the reset
    cyc(1, 4'd3, 16'h0100, 0, 4'd0, 16'h0, 16'h0);
    idle(2); lit("post_rst_coef", 1'b1, 256, 3, 1'b0);
    cyc(1, 4'd2, 16'h7000, 0, 4'd0, 16'h0, 16'h0);
    idle(2); lit("post_rst_nosat", 1'b1, 28672, 2, 1'b0);

    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
